// File: rtl/mem_resp_stage.sv
// MEM stage between EX and WB on a split-transaction data bus: holds loads until data_ok,
// buffers responses across WB stalls, drops flushed responses. Define MS_LOAD_FWD_EN to forward load data from MS.
module mem_resp_stage #(
    parameter int DATA_W          = 32,
    parameter int PAYLOAD_W       = 64,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   es_to_ms_valid,
    output logic                                   ms_allowin,
    input  logic [PAYLOAD_W-1:0]                   es_payload,
    input  logic [DATA_W-1:0]                      es_alu_result,
    input  logic                                   es_gr_we,
    input  logic [4:0]                             es_dest,
    input  logic                                   es_res_from_mem,
    input  logic [1:0]                             es_ld_size,
    input  logic                                   es_ld_unsigned,
    input  logic                                   es_req_outstanding,
    input  logic                                   data_sram_data_ok,
    input  logic [DATA_W-1:0]                      data_sram_rdata,
    input  logic                                   ms_flush_pipe,
    input  logic                                   ws_allowin,
    output logic                                   ms_to_ws_valid,
    output logic [PAYLOAD_W-1:0]                   ms_to_ws_payload,
    output logic                                   ms_to_ws_gr_we,
    output logic [4:0]                             ms_to_ws_dest,
    output logic [DATA_W-1:0]                      ms_to_ws_result,
    output logic                                   ms_fwd_valid,
    output logic [4:0]                             ms_fwd_dest,
    output logic [DATA_W-1:0]                      ms_fwd_result,
    output logic                                   ms_fwd_blocked,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   ms_discard_cnt
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW1   = CNT_W + 1;
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic                 ms_valid;
    logic [PAYLOAD_W-1:0] payload_r;
    logic [DATA_W-1:0]    alu_result_r;
    logic                 gr_we_r;
    logic [4:0]           dest_r;
    logic                 res_from_mem_r;
    logic [1:0]           ld_size_r;
    logic                 ld_unsigned_r;

    logic                 buf_valid;
    logic [DATA_W-1:0]    buf_data;
    logic [CNT_W-1:0]     discard_cnt;
    logic [CW1-1:0]       cnt_next;

    logic                 resp_drop;
    logic                 resp_hit;
    logic                 ms_ready_go;
    logic                 ms_leave;
    logic                 data_ready;

    logic [DATA_W-1:0]    load_src;
    logic [DATA_W-1:0]    lane;
    logic [DATA_W-1:0]    word_ext;
    logic [DATA_W-1:0]    load_data;

    // Responses owed to flushed instructions are consumed before MS may claim one.
    assign resp_drop      = data_sram_data_ok && (discard_cnt != '0);
    assign resp_hit       = data_sram_data_ok && (discard_cnt == '0) && ms_valid
                            && res_from_mem_r && !buf_valid;
    assign ms_ready_go    = !res_from_mem_r || buf_valid || resp_hit;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe;
    assign ms_leave       = ms_to_ws_valid && ws_allowin;

    always_comb begin
        load_src = buf_valid ? buf_data : data_sram_rdata;
        lane     = load_src >> {alu_result_r[OFF_W-1:0], 3'b000};
    end

    generate
        if (DATA_W == 64) begin : g_word64
            assign word_ext = {{(DATA_W-32){lane[31] & ~ld_unsigned_r}}, lane[31:0]};
        end else begin : g_word32
            assign word_ext = lane;
        end
    endgenerate

    always_comb begin
        load_data = word_ext;
        case (ld_size_r)
            2'd0:    load_data = {{(DATA_W-8){lane[7] & ~ld_unsigned_r}}, lane[7:0]};
            2'd1:    load_data = {{(DATA_W-16){lane[15] & ~ld_unsigned_r}}, lane[15:0]};
            2'd2:    load_data = word_ext;
            default: load_data = (DATA_W == 64) ? lane : word_ext;
        endcase
    end

    assign ms_to_ws_result  = res_from_mem_r ? load_data : alu_result_r;
    assign ms_to_ws_payload = payload_r;
    assign ms_to_ws_gr_we   = gr_we_r;
    assign ms_to_ws_dest    = dest_r;

`ifdef MS_LOAD_FWD_EN
    assign data_ready    = buf_valid || resp_hit;
    assign ms_fwd_result = ms_to_ws_result;
`else
    assign data_ready    = 1'b0;
    assign ms_fwd_result = alu_result_r;
`endif

    assign ms_fwd_valid   = ms_valid && gr_we_r;
    assign ms_fwd_dest    = dest_r;
    assign ms_fwd_blocked = ms_fwd_valid && res_from_mem_r && !data_ready;
    assign ms_discard_cnt = discard_cnt;

    // On flush, count the MS load still waiting plus any request EX has in flight.
    always_comb begin
        cnt_next = {1'b0, discard_cnt} - CW1'(resp_drop);
        if (ms_flush_pipe) begin
            cnt_next = cnt_next
                     + CW1'(ms_valid && res_from_mem_r && !buf_valid && !resp_hit)
                     + CW1'(es_req_outstanding);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_flush_pipe) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (ms_allowin && es_to_ms_valid) begin
            payload_r      <= es_payload;
            alu_result_r   <= es_alu_result;
            gr_we_r        <= es_gr_we;
            dest_r         <= es_dest;
            res_from_mem_r <= es_res_from_mem;
            ld_size_r      <= es_ld_size;
            ld_unsigned_r  <= es_ld_unsigned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ms_flush_pipe || ms_leave) begin
            buf_valid <= 1'b0;
        end else if (resp_hit) begin
            buf_valid <= 1'b1;
            buf_data  <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else begin
            discard_cnt <= cnt_next[CNT_W-1:0];
        end
    end

    a_resp_owned: assert property (@(posedge clk) disable iff (reset)
        data_sram_data_ok |-> (resp_drop || resp_hit));

    a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
        cnt_next <= CW1'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_mem_resp_stage.sv
// Bench for mem_resp_stage: directed scenarios with literal expectations plus randomized traffic
// against a tagged request-queue model of the bus and the MS slot.
module tb_mem_resp_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        es_to_ms_valid, ms_allowin;
    logic [63:0] es_payload;
    logic [31:0] es_alu_result;
    logic        es_gr_we;
    logic [4:0]  es_dest;
    logic        es_res_from_mem;
    logic [1:0]  es_ld_size;
    logic        es_ld_unsigned, es_req_outstanding;
    logic        data_ok;
    logic [31:0] rdata;
    logic        flush, ws_allowin;
    logic        ms_to_ws_valid;
    logic [63:0] ms_to_ws_payload;
    logic        ms_to_ws_gr_we;
    logic [4:0]  ms_to_ws_dest;
    logic [31:0] ms_to_ws_result;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_result;
    logic        ms_fwd_blocked;
    logic [1:0]  ms_discard_cnt;

    // 64-bit instance signals
    logic        w_es_valid, w_allowin, w_gr_we, w_load, w_uns, w_outstanding;
    logic [63:0] w_payload, w_alu, w_rdata, w_result, w_ws_payload, w_fwd_result;
    logic [1:0]  w_size, w_cnt;
    logic        w_data_ok, w_flush, w_ws_allowin, w_valid, w_ws_gr_we, w_fwd_valid, w_blocked;
    logic [4:0]  w_dest, w_ws_dest, w_fwd_dest;

    mem_resp_stage #(.DATA_W(32), .PAYLOAD_W(64), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_payload(es_payload), .es_alu_result(es_alu_result), .es_gr_we(es_gr_we),
        .es_dest(es_dest), .es_res_from_mem(es_res_from_mem), .es_ld_size(es_ld_size),
        .es_ld_unsigned(es_ld_unsigned), .es_req_outstanding(es_req_outstanding),
        .data_sram_data_ok(data_ok), .data_sram_rdata(rdata), .ms_flush_pipe(flush),
        .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_to_ws_payload(ms_to_ws_payload), .ms_to_ws_gr_we(ms_to_ws_gr_we),
        .ms_to_ws_dest(ms_to_ws_dest), .ms_to_ws_result(ms_to_ws_result),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result),
        .ms_fwd_blocked(ms_fwd_blocked), .ms_discard_cnt(ms_discard_cnt)
    );

    mem_resp_stage #(.DATA_W(64), .PAYLOAD_W(64), .MAX_OUTSTANDING(2)) dut64 (
        .clk(clk), .reset(reset), .es_to_ms_valid(w_es_valid), .ms_allowin(w_allowin),
        .es_payload(w_payload), .es_alu_result(w_alu), .es_gr_we(w_gr_we),
        .es_dest(w_dest), .es_res_from_mem(w_load), .es_ld_size(w_size),
        .es_ld_unsigned(w_uns), .es_req_outstanding(w_outstanding),
        .data_sram_data_ok(w_data_ok), .data_sram_rdata(w_rdata), .ms_flush_pipe(w_flush),
        .ws_allowin(w_ws_allowin), .ms_to_ws_valid(w_valid),
        .ms_to_ws_payload(w_ws_payload), .ms_to_ws_gr_we(w_ws_gr_we),
        .ms_to_ws_dest(w_ws_dest), .ms_to_ws_result(w_result),
        .ms_fwd_valid(w_fwd_valid), .ms_fwd_dest(w_fwd_dest), .ms_fwd_result(w_fwd_result),
        .ms_fwd_blocked(w_blocked), .ms_discard_cnt(w_cnt)
    );

    typedef struct {
        bit          valid;
        bit          load;
        bit          gr_we;
        logic [4:0]  dest;
        logic [63:0] payload;
        logic [31:0] alu;
        logic [1:0]  size;
        bit          uns;
        int          tag;
        bit          got;
        logic [31:0] data;
    } instr_t;

    typedef struct {
        int tag;
        bit dead;
    } req_t;

    instr_t ex, ms;
    req_t   bq[$];
    int     next_tag = 0;
    bit     ex_taken = 1'b1;

    bit          e_valid, e_allowin, e_fwd_valid, e_blocked, e_gr_we;
    logic [31:0] e_result, e_fwd_result;
    logic [63:0] e_payload;
    logic [4:0]  e_dest;
    int          e_cnt;
    bit          chk_en = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    assign es_to_ms_valid     = ex.valid;
    assign es_payload         = ex.payload;
    assign es_alu_result      = ex.alu;
    assign es_gr_we           = ex.gr_we;
    assign es_dest            = ex.dest;
    assign es_res_from_mem    = ex.load;
    assign es_ld_size         = ex.size;
    assign es_ld_unsigned     = ex.uns;
    assign es_req_outstanding = ex.valid && ex.load;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Lane extraction by plain arithmetic: shift down, mask to size, extend.
    function automatic logic [63:0] extract(input logic [63:0] d, input int off, input int size,
                                            input bit uns, input int w);
        int nb;
        logic [63:0] v, m;
        case (size)
            0: nb = 1;
            1: nb = 2;
            2: nb = 4;
            default: nb = (w == 64) ? 8 : 4;
        endcase
        v = d >> (8 * off);
        if (nb < 8) begin
            m = (64'd1 << (8 * nb)) - 64'd1;
            v = v & m;
            if (!uns && v[8*nb-1]) v = v | ~m;
        end
        if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
        return v;
    endfunction

    task automatic set_ex(input bit v, input bit ld, input logic [31:0] alu,
                          input logic [1:0] sz, input bit u, input bit gr);
        req_t r;
        ex.valid   = v;
        ex.load    = v && ld;
        ex.alu     = alu;
        ex.size    = sz;
        ex.uns     = u;
        ex.gr_we   = gr;
        ex.dest    = 5'($urandom);
        ex.payload = {$urandom, $urandom};
        ex.got     = 1'b0;
        ex.data    = '0;
        ex.tag     = -1;
        if (v && ld) begin
            ex.tag = next_tag++;
            r.tag  = ex.tag;
            r.dead = 1'b0;
            bq.push_back(r);
        end
    endtask

    task automatic eval_model();
        bit hit, have, ready;
        logic [31:0] d;
        logic [63:0] x;
        hit   = data_ok && (bq.size() > 0) && !bq[0].dead;
        have  = ms.got || hit;
        d     = ms.got ? ms.data : rdata;
        ready = !ms.load || have;
        x     = extract({32'd0, d}, int'(ms.alu[1:0]), int'(ms.size), ms.uns, 32);
        e_valid     = ms.valid && ready && !flush;
        e_allowin   = !ms.valid || (ready && ws_allowin);
        e_result    = ms.load ? x[31:0] : ms.alu;
        e_payload   = ms.payload;
        e_gr_we     = ms.gr_we;
        e_dest      = ms.dest;
        e_fwd_valid = ms.valid && ms.gr_we;
`ifdef MS_LOAD_FWD_EN
        e_blocked    = e_fwd_valid && ms.load && !have;
        e_fwd_result = e_result;
`else
        e_blocked    = e_fwd_valid && ms.load;
        e_fwd_result = ms.alu;
`endif
        e_cnt = 0;
        foreach (bq[i]) if (bq[i].dead) e_cnt++;
    endtask

    task automatic model_update();
        req_t f;
        if (reset) begin
            bq.delete();
            ms.valid = 1'b0;
            ms.got   = 1'b0;
            ex_taken = 1'b1;
            return;
        end
        if (data_ok) begin
            f = bq.pop_front();
            if (!f.dead) begin
                ms.got  = 1'b1;
                ms.data = rdata;
            end
        end
        if (flush) begin
            foreach (bq[i])
                if ((ms.valid && bq[i].tag == ms.tag) || (ex.valid && bq[i].tag == ex.tag))
                    bq[i].dead = 1'b1;
            ms.valid = 1'b0;
            ex_taken = 1'b1;
        end else if (e_allowin) begin
            ms       = ex;
            ms.got   = 1'b0;
            ex_taken = ex.valid;
        end else begin
            ex_taken = 1'b0;
        end
    endtask

    task automatic run_cycle();
        eval_model();
        @(posedge clk);
        #1;
        model_update();
        chk_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("to_ws_valid", 64'(ms_to_ws_valid), 64'(e_valid));
            check("allowin", 64'(ms_allowin), 64'(e_allowin));
            check("fwd_valid", 64'(ms_fwd_valid), 64'(e_fwd_valid));
            check("fwd_blocked", 64'(ms_fwd_blocked), 64'(e_blocked));
            check("discard_cnt", 64'(ms_discard_cnt), 64'(e_cnt));
            if (e_valid) begin
                check("result", 64'(ms_to_ws_result), 64'(e_result));
                check("payload", ms_to_ws_payload, e_payload);
                check("gr_we", 64'(ms_to_ws_gr_we), 64'(e_gr_we));
                check("dest", 64'(ms_to_ws_dest), 64'(e_dest));
            end
            if (e_fwd_valid) check("fwd_dest", 64'(ms_fwd_dest), 64'(e_dest));
            if (e_fwd_valid && !e_blocked) check("fwd_result", 64'(ms_fwd_result), 64'(e_fwd_result));
        end
    end

    initial begin
        bit legal;
        ms.valid = 1'b0; ms.got = 1'b0; ms.load = 1'b0; ms.tag = -1;
        reset = 1'b1; data_ok = 1'b0; rdata = '0; flush = 1'b0; ws_allowin = 1'b1;
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        w_es_valid = 1'b0; w_gr_we = 1'b1; w_load = 1'b1; w_uns = 1'b0; w_outstanding = 1'b0;
        w_payload = '0; w_alu = '0; w_rdata = '0; w_size = 2'd3; w_dest = 5'd7;
        w_data_ok = 1'b0; w_flush = 1'b0; w_ws_allowin = 1'b1;

        run_cycle();
        #1;
        check("rst_to_ws_valid", 64'(ms_to_ws_valid), 64'd0);
        check("rst_allowin", 64'(ms_allowin), 64'd1);
        check("rst_fwd_valid", 64'(ms_fwd_valid), 64'd0);
        check("rst_fwd_blocked", 64'(ms_fwd_blocked), 64'd0);
        check("rst_discard_cnt", 64'(ms_discard_cnt), 64'd0);
        run_cycle();
        reset = 1'b0;

        // Non-load passes through in one cycle
        set_ex(1, 0, 32'h1234, 2'd0, 0, 1);
        run_cycle();
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        #1;
        check("nl_valid", 64'(ms_to_ws_valid), 64'd1);
        check("nl_result", 64'(ms_to_ws_result), 64'h1234);
        run_cycle();

        // Signed byte load at offset 2, response three cycles late
        set_ex(1, 1, 32'h1002, 2'd0, 0, 1);
        run_cycle();
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ldb_wait_valid", 64'(ms_to_ws_valid), 64'd0);
            check("ldb_wait_blocked", 64'(ms_fwd_blocked), 64'd1);
            run_cycle();
        end
        data_ok = 1'b1; rdata = 32'h80FF7F00;
        #1;
        check("ldb_valid", 64'(ms_to_ws_valid), 64'd1);
        check("ldb_result", 64'(ms_to_ws_result), 64'hFFFF_FFFF);
`ifdef MS_LOAD_FWD_EN
        check("ldb_fwd_blocked", 64'(ms_fwd_blocked), 64'd0);
        check("ldb_fwd_result", 64'(ms_fwd_result), 64'hFFFF_FFFF);
`else
        check("ldb_fwd_blocked", 64'(ms_fwd_blocked), 64'd1);
        check("ldb_fwd_result", 64'(ms_fwd_result), 64'h1002);
`endif
        run_cycle();
        data_ok = 1'b0;

        // Same lane, zero-extended
        set_ex(1, 1, 32'h1002, 2'd0, 1, 1);
        run_cycle();
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        data_ok = 1'b1;
        #1;
        check("ldbu_result", 64'(ms_to_ws_result), 64'h0000_00FF);
        run_cycle();
        data_ok = 1'b0;

        // Response while WB stalls is held in the buffer
        set_ex(1, 1, 32'h2000, 2'd2, 0, 1);
        run_cycle();
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        data_ok = 1'b1; rdata = 32'hCAFE_F00D; ws_allowin = 1'b0;
        #1;
        check("stall_first", 64'(ms_to_ws_result), 64'hCAFE_F00D);
        run_cycle();
        data_ok = 1'b0; rdata = 32'h1111_1111;
        #1;
        check("stall_hold_valid", 64'(ms_to_ws_valid), 64'd1);
        check("stall_hold_result", 64'(ms_to_ws_result), 64'hCAFE_F00D);
        run_cycle();
        ws_allowin = 1'b1;
        #1;
        check("stall_release", 64'(ms_to_ws_result), 64'hCAFE_F00D);
        run_cycle();
        #1;
        check("stall_gone", 64'(ms_to_ws_valid), 64'd0);

        // Flush with an MS load waiting and an EX request in flight
        set_ex(1, 1, 32'h3000, 2'd2, 0, 1);
        run_cycle();
        set_ex(1, 1, 32'h3004, 2'd2, 0, 1);
        flush = 1'b1;
        run_cycle();
        flush = 1'b0;
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        data_ok = 1'b1; rdata = 32'h0000_AAAA;
        #1;
        check("flush_cnt2", 64'(ms_discard_cnt), 64'd2);
        run_cycle();
        rdata = 32'h0000_BBBB;
        #1;
        check("flush_cnt1", 64'(ms_discard_cnt), 64'd1);
        run_cycle();
        data_ok = 1'b0;
        #1;
        check("flush_cnt0", 64'(ms_discard_cnt), 64'd0);
        set_ex(1, 1, 32'h3008, 2'd2, 0, 1);
        run_cycle();
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        data_ok = 1'b1; rdata = 32'h0000_CCCC;
        #1;
        check("flush_next_valid", 64'(ms_to_ws_valid), 64'd1);
        check("flush_next_result", 64'(ms_to_ws_result), 64'h0000_CCCC);
        run_cycle();
        data_ok = 1'b0;

        // 64-bit instance: dword and half at offset 6
        w_es_valid = 1'b1; w_size = 2'd3; w_alu = 64'h100; w_outstanding = 1'b1;
        run_cycle();
        w_es_valid = 1'b0; w_outstanding = 1'b0; w_data_ok = 1'b1;
        w_rdata = 64'h8000_0000_0000_0001;
        #1;
        check("w64_dword_valid", 64'(w_valid), 64'd1);
        check("w64_dword", w_result, 64'h8000_0000_0000_0001);
        run_cycle();
        w_data_ok = 1'b0; w_es_valid = 1'b1; w_size = 2'd1; w_alu = 64'h106; w_outstanding = 1'b1;
        run_cycle();
        w_es_valid = 1'b0; w_outstanding = 1'b0; w_data_ok = 1'b1;
        w_rdata = 64'h8000_1234_5678_9ABC;
        #1;
        check("w64_half6", w_result, 64'hFFFF_FFFF_FFFF_8000);
        run_cycle();
        w_data_ok = 1'b0;

        // Randomized traffic with one mid-run reset
        for (int c = 0; c < 4000; c++) begin
            if (c == 2000 || c == 2001) begin
                reset = 1'b1; data_ok = 1'b0; flush = 1'b0;
                set_ex(0, 0, 32'd0, 2'd0, 0, 0);
            end else begin
                reset = 1'b0;
                if (ex_taken || !ex.valid)
                    set_ex(($urandom % 10) < 7, 1'($urandom), $urandom, 2'($urandom),
                           1'($urandom), 1'($urandom));
                legal = (bq.size() > 0) &&
                        (bq[0].dead || (ms.valid && ms.load && !ms.got && bq[0].tag == ms.tag));
                data_ok    = legal && ($urandom % 2 == 0);
                rdata      = $urandom;
                ws_allowin = ($urandom % 4) != 0;
                flush      = ($urandom % 16 == 0) && ((bq.size() - int'(data_ok)) <= 2);
            end
            run_cycle();
        end
        flush = 1'b0; data_ok = 1'b0;
        set_ex(0, 0, 32'd0, 2'd0, 0, 0);
        run_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
